// File: rtl/shift_ser_ctrl.sv
// Purpose : parallel-to-serial frame shifter, MSB first, one bit per tick_i strobe.
// Latency : sx_o carries the MSB the cycle after the handshake; done_o pulses the cycle after the final tick.
// Backpressure: in_ready_o is high only in IDLE; offers made at any other time are ignored, never queued.
//
// Optional feature: define SHIFT_SER_CTRL_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   in_valid_i/in_data_i  parallel word offer; in_ready_o accepts it
//   tick_i                bit-time strobe; abort_i drops the frame in progress
//   sx_o, frame_o         serial data and frame envelope
//   done_o                one-cycle pulse on frame completion
//   bit_cnt_o             bits already shifted out in the current frame
module shift_ser_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       in_ready_o,
    input  logic                       tick_i,
    input  logic                       abort_i,
    output logic                       sx_o,
    output logic                       frame_o,
    output logic                       done_o,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

`ifdef SHIFT_SER_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_frame;
    logic             r_done;
`ifdef SHIFT_SER_CTRL_PARITY_EN
    logic             r_par;
`endif

    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_last_bit;

    assign w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
    assign w_last_bit  = (r_cnt == LAST_BIT);

    // sx_o is the shift register MSB directly. The register is all-zero outside
    // SHIFT/PARITY (zero fill empties it after the last data bit, abort and
    // reset clear it), so sx_o is 0 in IDLE and DONE without extra gating.
    assign sx_o       = r_shreg[WIDTH-1];
    assign in_ready_o = r_ready;
    assign frame_o    = r_frame;
    assign done_o     = r_done;
    assign bit_cnt_o  = r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHIFT_SER_CTRL_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort_i has no effect here; only the handshake matters.
                    if (in_valid_i) begin
                        r_state <= S_SHIFT;
                        r_shreg <= in_data_i;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_frame <= 1'b1;
`ifdef SHIFT_SER_CTRL_PARITY_EN
                        r_par   <= ^in_data_i;
`endif
                    end
                end

                S_SHIFT: begin
                    // abort wins over a coincident tick.
                    if (abort_i) begin
                        r_state <= S_IDLE;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_frame <= 1'b0;
                    end else if (tick_i) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last_bit) begin
`ifdef SHIFT_SER_CTRL_PARITY_EN
                            // Park the parity bit in the MSB so it drives sx_o.
                            r_state <= S_PARITY;
                            r_shreg <= {r_par, {(WIDTH-1){1'b0}}};
`else
                            r_state <= S_DONE;
                            r_shreg <= '0;
                            r_frame <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_shreg <= w_shreg_nxt;
                        end
                    end
                end

`ifdef SHIFT_SER_CTRL_PARITY_EN
                S_PARITY: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_frame <= 1'b0;
                    end else if (tick_i) begin
                        r_state <= S_DONE;
                        r_shreg <= '0;
                        r_frame <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    // Single-cycle state; the count reads WIDTH here and is
                    // cleared on the way back to IDLE.
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_shreg <= '0;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_frame <= 1'b0;
                end
            endcase
        end
    end

    // FULL_CNT documents the terminal count that bit_cnt_o shows once all
    // data bits are out; it is reached by the increment above.
    logic w_unused_full;
    assign w_unused_full = ^FULL_CNT;

endmodule

// File: tb/tb_shift_ser_ctrl.sv
`timescale 1ns/1ps
module tb_shift_ser_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);
`ifdef SHIFT_SER_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             in_valid_i = 1'b0;
    logic [WIDTH-1:0] in_data_i  = '0;
    logic             tick_i     = 1'b0;
    logic             abort_i    = 1'b0;
    logic             in_ready_o;
    logic             sx_o;
    logic             frame_o;
    logic             done_o;
    logic [CW-1:0]    bit_cnt_o;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    bit exp_q[$];   // expected serial bits, front = bit currently on sx_o

    always #5 clk = ~clk;

    shift_ser_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .tick_i     (tick_i),
        .abort_i    (abort_i),
        .sx_o       (sx_o),
        .frame_o    (frame_o),
        .done_o     (done_o),
        .bit_cnt_o  (bit_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
        if (PAR != 0) exp_q.push_back(^d);
    endtask

    // Checks sx_o against the scoreboard for the current cycle, retires the
    // bit if a tick is applied, then advances one clock and samples #1 later.
    task automatic step();
        if (frame_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sx_no_expected: observed frame_o=1 sx_o=%0b expected idle line", sx_o);
            end else begin
                check("sx", {31'd0, sx_o}, {31'd0, exp_q[0]});
                if (tick_i && !abort_i) void'(exp_q.pop_front());
            end
            if (abort_i) exp_q.delete();
        end
        @(posedge clk);
        #1;
        if (done_o === 1'b1) done_cnt++;
    endtask

    task automatic load(input logic [WIDTH-1:0] d);
        in_data_i  = d;
        in_valid_i = 1'b1;
        check("ready_at_load", in_ready_o, 1);
        push_word(d);
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic run_until_done(input int bound, input string tag);
        int n = 0;
        while (done_o !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check(tag, done_o, 1);
    endtask

    task automatic frame_every_cycle(input logic [WIDTH-1:0] d);
        load(d);
        tick_i = 1'b1;
        for (int c = 0; c < WIDTH + PAR; c++) begin
            check("frame_hi", frame_o, 1);
            check("bit_cnt", bit_cnt_o, (c < WIDTH) ? c : WIDTH);
            check("no_done_mid", done_o, 0);
            step();
        end
        check("done_pulse", done_o, 1);
        check("frame_lo_in_done", frame_o, 0);
        check("sx_lo_in_done", sx_o, 0);
        check("ready_lo_in_done", in_ready_o, 0);
        tick_i = 1'b0;
        step();
        check("ready_after_done", in_ready_o, 1);
        check("done_single", done_o, 0);
        check("cnt_idle", bit_cnt_o, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int ticks;
        int k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready_o, 1);
        check("rst_sx", sx_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cnt", bit_cnt_o, 0);
        reset = 1'b0;
        step();

        // 8'hA5 with a tick every cycle
        frame_every_cycle(8'hA5);

        // 8'h07: parity bit 1 follows the data when the feature is compiled in
        frame_every_cycle(8'h07);

        // 8'hFF with a tick every third cycle: each bit held, count steps 0..8
        done_cnt = 0;
        load(8'hFF);
        ticks = 0;
        k = 0;
        while (done_o !== 1'b1 && k < 60) begin
            tick_i = (k % 3 == 2);
            if (frame_o === 1'b1) begin
                check("cnt_sparse", bit_cnt_o, (ticks < WIDTH) ? ticks : WIDTH);
                if (tick_i) ticks++;
            end
            step();
            k++;
        end
        check("sparse_done", done_o, 1);
        check("sparse_ticks", ticks, WIDTH + PAR);
        tick_i = 1'b0;
        repeat (3) step();
        check("sparse_done_once", done_cnt, 1);
        check("sparse_drained", exp_q.size(), 0);

        // 8'hC3 aborted together with a tick after 4 ticks
        load(8'hC3);
        tick_i = 1'b1;
        repeat (4) step();
        check("cnt_before_abort", bit_cnt_o, 4);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        tick_i  = 1'b0;
        check("abort_ready", in_ready_o, 1);
        check("abort_frame", frame_o, 0);
        check("abort_cnt", bit_cnt_o, 0);
        check("abort_sx", sx_o, 0);
        done_cnt = 0;
        repeat (3) step();
        check("abort_no_done", done_cnt, 0);

        // abort in IDLE is ignored: the word is still captured and sent
        abort_i = 1'b1;
        load(8'h3C);
        abort_i = 1'b0;
        check("idle_abort_ignored", frame_o, 1);
        tick_i = 1'b1;
        run_until_done(40, "idle_abort_frame_done");
        tick_i = 1'b0;
        step();
        check("idle_abort_drained", exp_q.size(), 0);

        // Back-to-back with in_valid_i held high: 8'h01 then 8'h80
        tick_i     = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'h01;
        check("b2b_ready_first", in_ready_o, 1);
        push_word(8'h01);
        step();
        in_data_i = 8'h80;
        run_until_done(40, "b2b_first_done");
        check("b2b_ready_lo_in_done", in_ready_o, 0);
        step();
        check("b2b_ready_idle", in_ready_o, 1);
        check("b2b_frame_lo_idle", frame_o, 0);
        push_word(8'h80);
        step();
        in_valid_i = 1'b0;
        check("b2b_second_frame", frame_o, 1);
        check("b2b_second_cnt", bit_cnt_o, 0);
        run_until_done(40, "b2b_second_done");
        tick_i = 1'b0;
        step();
        check("b2b_drained", exp_q.size(), 0);

        // Reset asserted mid-frame: outputs return to reset values at once
        load(8'hAA);
        tick_i = 1'b1;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ready", in_ready_o, 1);
        check("midrst_sx", sx_o, 0);
        check("midrst_frame", frame_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_cnt", bit_cnt_o, 0);
        exp_q.delete();
        tick_i = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        done_cnt = 0;
        repeat (3) step();
        check("postrst_ready", in_ready_o, 1);
        check("postrst_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of stimulus, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shift_ser_ctrl.md
SHIFT_SER_CTRL -- requirements
Module: shift_ser_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, is the number of data bits per frame; legal values are 2 to 32.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: in_valid_i  input  1  a parallel word is offered.
REQ-005: in_data_i  input  WIDTH  the parallel word, sampled only on a handshake.
REQ-006: in_ready_o  output  1  the block accepts a word this cycle.
REQ-007: tick_i  input  1  shift-pacing strobe; one bit time is one tick.
REQ-008: abort_i  input  1  synchronous abort of the frame in progress.
REQ-009: sx_o  output  1  serial data out, MSB first.
REQ-010: frame_o  output  1  high while bits are being driven on sx_o.
REQ-011: done_o  output  1  one-cycle pulse when a frame completes.
REQ-012: bit_cnt_o  output  $clog2(WIDTH+1)  number of bits already shifted out in the current frame.

Function
REQ-013: The FSM SHALL have the states IDLE, SHIFT, PARITY (present only when the macro is compiled in) and DONE.
REQ-014: IDLE: in_ready_o=1, sx_o=0, frame_o=0, bit_cnt_o=0; in_valid_i&in_ready_o captures in_data_i into an internal WIDTH-bit shift register and moves to SHIFT next cycle.
REQ-015: SHIFT: in_ready_o=0, frame_o=1, sx_o=shreg[WIDTH-1]; on tick_i, shreg shifts left by one with 0 fill and bit_cnt_o increments.
REQ-016: SHIFT: a tick_i while bit_cnt_o==WIDTH-1 SHALL leave SHIFT (to PARITY if enabled, else DONE), and bit_cnt_o becomes WIDTH.
REQ-017: Without tick_i, the state, sx_o and bit_cnt_o SHALL hold indefinitely; there is no timeout.
REQ-018: DONE: lasts exactly one cycle; done_o=1, frame_o=0, sx_o=0, in_ready_o=0; the next state is IDLE.
REQ-019: done_o SHALL be 0 in every state except DONE.
REQ-020: Back-to-back frames: a new word is accepted no earlier than the IDLE cycle that follows DONE, giving a minimum of one idle cycle between frames.
REQ-021: abort_i in SHIFT or PARITY SHALL force IDLE next cycle, with no done_o and with bit_cnt_o cleared.
REQ-022: abort_i SHALL take priority over tick_i in the same cycle.
REQ-023: abort_i SHALL be ignored in IDLE and DONE.
REQ-024: in_valid_i while in_ready_o=0 SHALL be ignored; no word is captured and no error is flagged.

Reset
REQ-025: While reset is high, the block SHALL be in IDLE with the shift register cleared.
REQ-026: While reset is high, the outputs SHALL be in_ready_o=1, sx_o=0, frame_o=0, done_o=0, bit_cnt_o=0.
REQ-027: Reset asserted mid-frame SHALL discard the frame immediately (asynchronously), with no done_o.

Configuration
REQ-028: The macro SHIFT_SER_CTRL_PARITY_EN SHALL control the PARITY state.
REQ-029: With SHIFT_SER_CTRL_PARITY_EN defined, PARITY follows SHIFT.
  - PARITY: frame_o=1; sx_o = even-parity bit, the XOR of the captured word.
  - bit_cnt_o stays at WIDTH.
  - tick_i moves to DONE; abort_i behaves as in SHIFT.
REQ-030: Without SHIFT_SER_CTRL_PARITY_EN, the PARITY state and the parity logic SHALL be absent, and SHIFT goes directly to DONE.

Verification (WIDTH=8)
REQ-031: Reset asserted mid-frame -> all outputs at reset values in the same cycle; after release, in_ready_o=1 and no done_o.
REQ-032: Load 8'hA5 with tick_i=1 every cycle, parity off -> sx_o=1,0,1,0,0,1,0,1 over 8 cycles with frame_o=1; done_o pulses in the 9th cycle after the handshake; in_ready_o=1 in the 10th.
REQ-033: Load 8'h07 with the parity macro defined, tick every cycle -> sx_o=0,0,0,0,0,1,1,1 then parity 1; done_o pulses in the 10th cycle after the handshake.
REQ-034: Load 8'hFF with tick_i every 3rd cycle -> each bit held 3 cycles; bit_cnt_o steps 0..8; done_o pulses once.
REQ-035: Load 8'hC3 and assert abort_i together with tick_i after 4 ticks -> IDLE next cycle, done_o never asserted, bit_cnt_o=0, next word accepted.
REQ-036: Hold in_valid_i=1 continuously with words 8'h01 and 8'h80 -> 8'h01 is accepted first and 8'h80 only in the IDLE cycle after done_o; no word is captured while in_ready_o=0.
